// File: rtl/ann_pkg.sv
// Shared types and default sizing for the neural-network layer sequencer.
// Imported by the interface, the counter and the sequencer top.
package ann_pkg;

    localparam int DEF_N_IN     = 62;
    localparam int DEF_N_NEURON = 30;
    localparam int DEF_ADDR_W   = 16;
    localparam int CNT_W        = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_DRAIN,
        S_ACT,
        S_WRITE,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// Control/address bundle between the layer sequencer and its datapath.
// The sequencer uses the master view; the datapath (or a bench) uses slave.
interface layer_sequencer_if
    import ann_pkg::*;
    #(parameter int ADDR_W = DEF_ADDR_W);

    logic              start;
    logic              busy;
    logic              rd_en;
    logic [CNT_W-1:0]  in_addr;
    logic [ADDR_W-1:0] w_addr;
    logic              mac_clr;
    logic              mac_en;
    logic              act_en;
    logic              out_we;
    logic [CNT_W-1:0]  out_addr;
    logic              done;

    modport master (
        input  start,
        output busy, rd_en, in_addr, w_addr, mac_clr, mac_en,
        output act_en, out_we, out_addr, done
    );

    modport slave (
        output start,
        input  busy, rd_en, in_addr, w_addr, mac_clr, mac_en,
        input  act_en, out_we, out_addr, done
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo-MODULUS counter with synchronous clear; 'last' flags the final count
// so the owner can decide when a loop is finished.
module mod_counter
    import ann_pkg::*;
    #(
        parameter int MODULUS = 2,
        parameter int WIDTH   = CNT_W
    ) (
        input  logic             clk,
        input  logic             rst,
        input  logic             clr,
        input  logic             inc,
        output logic [WIDTH-1:0] count,
        output logic             last
    );

    assign last = (count == WIDTH'(MODULUS - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one fully-connected layer: per neuron it clears the MAC, streams
// N_IN input/weight reads, drains the pipeline, activates and writes back.
module layer_sequencer
    import ann_pkg::*;
    #(
        parameter int N_IN     = DEF_N_IN,
        parameter int N_NEURON = DEF_N_NEURON,
        parameter int ADDR_W   = DEF_ADDR_W
    ) (
        input logic               clk,
        input logic               rst,
        layer_sequencer_if.master bus
    );

    if (N_IN < 1 || N_IN > 1023 || N_NEURON < 1 || N_NEURON > 1023 ||
        longint'(N_IN) * longint'(N_NEURON) > (longint'(1) << ADDR_W)) begin : g_bad_params
        $error("layer_sequencer: illegal N_IN/N_NEURON/ADDR_W combination");
    end

    seq_state_t        state;
    logic              busy_q, rd_en_q, mac_clr_q, mac_en_q, act_en_q, out_we_q, done_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [CNT_W-1:0]  in_idx, neuron;
    logic              in_last, neuron_last;
    logic              in_clr, in_inc, n_clr, n_inc;

    assign in_clr = (state == S_CLEAR);
    assign in_inc = (state == S_MAC);
    assign n_clr  = (state == S_IDLE);
    assign n_inc  = (state == S_WRITE);

    mod_counter #(.MODULUS(N_IN), .WIDTH(CNT_W)) u_in_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (in_clr),
        .inc   (in_inc),
        .count (in_idx),
        .last  (in_last)
    );

    mod_counter #(.MODULUS(N_NEURON), .WIDTH(CNT_W)) u_neuron_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (n_clr),
        .inc   (n_inc),
        .count (neuron),
        .last  (neuron_last)
    );

    // Strobes are registered together with the state they belong to, so each
    // arm sets the strobes of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            mac_clr_q <= 1'b0;
            mac_en_q  <= 1'b0;
            act_en_q  <= 1'b0;
            out_we_q  <= 1'b0;
            done_q    <= 1'b0;
            w_addr_q  <= '0;
        end else begin
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b0;
            mac_clr_q <= 1'b0;
            act_en_q  <= 1'b0;
            out_we_q  <= 1'b0;
            done_q    <= 1'b0;
            mac_en_q  <= rd_en_q;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state     <= S_CLEAR;
                        mac_clr_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state   <= S_MAC;
                    rd_en_q <= 1'b1;
                end
                S_MAC: begin
                    if (in_last) begin
                        state <= S_DRAIN;
                    end else begin
                        rd_en_q <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    state    <= S_ACT;
                    act_en_q <= 1'b1;
                end
                S_ACT: begin
                    state    <= S_WRITE;
                    out_we_q <= 1'b1;
                end
                S_WRITE: begin
                    if (neuron_last) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end else begin
                        state     <= S_CLEAR;
                        mac_clr_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
            // Neurons are visited in order, so a running count of reads equals neuron*N_IN+in_idx.
            if (state == S_IDLE) begin
                w_addr_q <= '0;
            end else if (state == S_MAC) begin
                w_addr_q <= w_addr_q + 1'b1;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.in_addr  = in_idx;
    assign bus.w_addr   = w_addr_q;
    assign bus.mac_clr  = mac_clr_q;
    assign bus.mac_en   = mac_en_q;
    assign bus.act_en   = act_en_q;
    assign bus.out_we   = out_we_q;
    assign bus.out_addr = neuron;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench: a 4x3 layer checked through a read/write scoreboard and
// a 1x1 layer checked cycle by cycle from a vector table.
module tb_layer_sequencer;

    localparam int A_N_IN     = 4;
    localparam int A_N_NEURON = 3;
    localparam int A_LATENCY  = A_N_NEURON * (A_N_IN + 4);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    layer_sequencer_if #(.ADDR_W(16)) bus_a ();
    layer_sequencer_if #(.ADDR_W(8))  bus_b ();

    layer_sequencer #(.N_IN(A_N_IN), .N_NEURON(A_N_NEURON), .ADDR_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    layer_sequencer #(.N_IN(1), .N_NEURON(1), .ADDR_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        logic [15:0] w;
        logic [9:0]  idx;
    } rd_exp_t;

    typedef struct {
        logic       start;
        logic [6:0] exp;
    } vec_t;

    int          vectors     = 0;
    int          miscompares = 0;
    rd_exp_t     rd_q[$];
    logic [9:0]  wr_q[$];
    bit          mon_on = 1'b0;
    bit          sb_on  = 1'b0;
    logic        prev_rd_a = 1'b0;
    logic        prev_rd_b = 1'b0;
    vec_t        tbl[15];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic sa, input logic sb);
        bus_a.start = sa;
        bus_b.start = sb;
        step();
    endtask

    function automatic logic [6:0] strobes_a();
        return {bus_a.busy, bus_a.rd_en, bus_a.mac_clr, bus_a.mac_en,
                bus_a.act_en, bus_a.out_we, bus_a.done};
    endfunction

    function automatic logic [6:0] strobes_b();
        return {bus_b.busy, bus_b.rd_en, bus_b.mac_clr, bus_b.mac_en,
                bus_b.act_en, bus_b.out_we, bus_b.done};
    endfunction

    task automatic push_run(input int runs);
        for (int r = 0; r < runs; r++) begin
            for (int n = 0; n < A_N_NEURON; n++) begin
                for (int i = 0; i < A_N_IN; i++) begin
                    rd_exp_t e;
                    e.w   = 16'(n * A_N_IN + i);
                    e.idx = 10'(i);
                    rd_q.push_back(e);
                end
                wr_q.push_back(10'(n));
            end
        end
    endtask

    task automatic run_to_done(input string name, output int cnt);
        int busy_low;
        cnt      = 0;
        busy_low = 0;
        while (bus_a.done !== 1'b1 && cnt < 100) begin
            if (bus_a.busy !== 1'b1) busy_low++;
            step();
            cnt++;
        end
        check_output({name, "_busy_low_cycles"}, busy_low, 0);
    endtask

    // Sampled on the falling edge, half a cycle away from the DUT's active edge.
    always @(negedge clk) begin
        rd_exp_t e;
        logic [9:0] wa;
        if (mon_on) begin
            check_output("strobe_excl_a", $countones({bus_a.rd_en, bus_a.mac_clr, bus_a.act_en,
                                                      bus_a.out_we, bus_a.done}) <= 1, 1);
            check_output("strobe_excl_b", $countones({bus_b.rd_en, bus_b.mac_clr, bus_b.act_en,
                                                      bus_b.out_we, bus_b.done}) <= 1, 1);
            check_output("mac_en_a", bus_a.mac_en, prev_rd_a);
            check_output("mac_en_b", bus_b.mac_en, prev_rd_b);
            if (sb_on && bus_a.rd_en === 1'b1) begin
                check_output("pending_reads", rd_q.size() > 0, 1);
                if (rd_q.size() > 0) begin
                    e = rd_q.pop_front();
                    check_output("w_addr", bus_a.w_addr, e.w);
                    check_output("in_addr", bus_a.in_addr, e.idx);
                end
            end
            if (sb_on && bus_a.out_we === 1'b1) begin
                check_output("pending_writes", wr_q.size() > 0, 1);
                if (wr_q.size() > 0) begin
                    wa = wr_q.pop_front();
                    check_output("out_addr", bus_a.out_addr, wa);
                end
            end
        end
        prev_rd_a = (rst || !mon_on) ? 1'b0 : bus_a.rd_en;
        prev_rd_b = (rst || !mon_on) ? 1'b0 : bus_b.rd_en;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        int dones;

        // {busy, rd_en, mac_clr, mac_en, act_en, out_we, done} after each edge of the 1x1 layer
        tbl[0]  = '{1'b1, 7'b1010000};
        tbl[1]  = '{1'b0, 7'b1100000};
        tbl[2]  = '{1'b0, 7'b1001000};
        tbl[3]  = '{1'b1, 7'b1000100};
        tbl[4]  = '{1'b0, 7'b1000010};
        tbl[5]  = '{1'b0, 7'b1000001};
        tbl[6]  = '{1'b1, 7'b0000000};
        tbl[7]  = '{1'b0, 7'b0000000};
        tbl[8]  = '{1'b1, 7'b1010000};
        tbl[9]  = '{1'b0, 7'b1100000};
        tbl[10] = '{1'b1, 7'b1001000};
        tbl[11] = '{1'b0, 7'b1000100};
        tbl[12] = '{1'b0, 7'b1000010};
        tbl[13] = '{1'b1, 7'b1000001};
        tbl[14] = '{1'b0, 7'b0000000};

        rst         = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check_output("reset_state_a", {strobes_a(), bus_a.in_addr, bus_a.out_addr, bus_a.w_addr}, 64'h0);
        check_output("reset_state_b", {strobes_b(), bus_b.in_addr, bus_b.out_addr, bus_b.w_addr}, 64'h0);
        mon_on = 1'b1;
        sb_on  = 1'b1;

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(1'b0, tbl[i].start);
            check_output($sformatf("tbl_b[%0d]", i), strobes_b(), tbl[i].exp);
        end

        // Single 4x3 layer: latency, busy throughout, address streams via scoreboard
        push_run(1);
        apply_stimulus(1'b1, 1'b0);
        bus_a.start = 1'b0;
        check_output("first_cycle_a", strobes_a(), 7'b1010000);
        run_to_done("single_run", cnt);
        check_output("done_latency_a", cnt, A_LATENCY);
        check_output("busy_at_done_a", bus_a.busy, 1);
        step();
        check_output("idle_after_done_a", strobes_a(), 7'b0000000);
        check_output("reads_left", rd_q.size(), 0);
        check_output("writes_left", wr_q.size(), 0);

        // start held high: exactly one layer, next one only after IDLE is seen
        push_run(2);
        apply_stimulus(1'b1, 1'b0);
        dones = 0;
        for (int j = 1; j <= A_LATENCY + 1; j++) begin
            step();
            if (bus_a.done === 1'b1) dones++;
        end
        check_output("held_start_dones", dones, 1);
        check_output("held_start_idle_gap", strobes_a(), 7'b0000000);
        step();
        check_output("held_start_restart", strobes_a(), 7'b1010000);
        bus_a.start = 1'b0;
        run_to_done("held_run2", cnt);
        check_output("held_run2_latency", cnt, A_LATENCY);
        step();
        check_output("reads_left_held", rd_q.size(), 0);
        check_output("writes_left_held", wr_q.size(), 0);

        // Reset in the 2nd MAC cycle of neuron 1, then a clean restart from w_addr 0
        push_run(1);
        apply_stimulus(1'b1, 1'b0);
        bus_a.start = 1'b0;
        repeat (A_N_IN + 6) step();
        check_output("pre_reset_rd_en", bus_a.rd_en, 1);
        check_output("pre_reset_w_addr", bus_a.w_addr, A_N_IN + 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_q.delete();
        wr_q.delete();
        check_output("mid_mac_reset_a", {strobes_a(), bus_a.in_addr, bus_a.out_addr, bus_a.w_addr}, 64'h0);
        push_run(1);
        apply_stimulus(1'b1, 1'b0);
        bus_a.start = 1'b0;
        run_to_done("post_reset_run", cnt);
        check_output("post_reset_latency", cnt, A_LATENCY);
        step();
        check_output("reads_left_reset", rd_q.size(), 0);

        // rst wins over start at the same edge
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b1);
        rst = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        check_output("rst_priority_a", strobes_a(), 7'b0000000);
        check_output("rst_priority_b", strobes_b(), 7'b0000000);
        step();
        check_output("rst_priority_no_latch", {strobes_a(), strobes_b()}, 14'h0);

        // Random starts: the monitor keeps checking strobe exclusivity and mac_en
        sb_on = 1'b0;
        for (int j = 0; j < 300; j++) begin
            apply_stimulus($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
        end
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (A_LATENCY + 4) step();
        check_output("final_idle_a", bus_a.busy, 0);
        check_output("final_idle_b", bus_b.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
